// File: rtl/if_fetch_stage.sv
// if_fetch_stage: instruction-fetch stage feeding the IF/ID register.
// Issues one SRAM-like fetch at a time, buffers the returned instruction
// for ID and steers fetch_pc on branch / exception / ertn redirects,
// discarding any response that belongs to the abandoned path.
// Optional build macro IF_ADEF_EN: a misaligned fetch_pc raises an ADEF
// fault in the buffer instead of issuing a request.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c000000,
    parameter logic [31:0] NOP_INST = 32'h02800000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_allow_in,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        wb_ex,
    input  logic [31:0] ex_entry,
    input  logic        wb_is_ertn,
    input  logic [31:0] ertn_pc,
    output logic        inst_sram_req,
    output logic [31:0] inst_sram_addr,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata,
    output logic        if_ready_go,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_ex_adef
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    logic [1:0]  state;
    logic [31:0] fetch_pc;
    logic [31:0] redir_pc;
    logic        redir_valid;
    logic        discard;

    logic        redir;
    logic [31:0] redir_tgt;
    logic        adef_fault;

    // Pick the redirect target: exception beats ertn beats branch.
    always_comb begin
        redir     = wb_ex | wb_is_ertn | br_taken;
        redir_tgt = br_target;
        if (wb_ex)
            redir_tgt = ex_entry;
        else if (wb_is_ertn)
            redir_tgt = ertn_pc;
    end

`ifdef IF_ADEF_EN
    assign adef_fault = (state == S_REQ) && (fetch_pc[1:0] != 2'b00);
`else
    assign adef_fault = 1'b0;
`endif

    // A faulting fetch never reaches the SRAM.
    assign inst_sram_req  = (state == S_REQ) && !adef_fault;
    assign inst_sram_addr = fetch_pc;

    // Fetch FSM, fetch PC, pending-redirect bookkeeping and the ID buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            fetch_pc    <= RESET_PC;
            redir_pc    <= RESET_PC;
            redir_valid <= 1'b0;
            discard     <= 1'b0;
            if_ready_go <= 1'b0;
            if_pc       <= 32'h1bfffffc;
            if_inst     <= NOP_INST;
            if_ex_adef  <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_HOLD: begin
                    // Redirect wins over a same-cycle consume.
                    if (redir) begin
                        fetch_pc    <= redir_tgt;
                        if_ready_go <= 1'b0;
                        if_inst     <= NOP_INST;
                        if_ex_adef  <= 1'b0;
                        state       <= S_REQ;
                    end else if (state == S_IDLE) begin
                        state <= S_REQ;
                    end else if (id_allow_in) begin
                        if_ready_go <= 1'b0;
                        state       <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (adef_fault) begin
                        // No request went out, so a redirect can be taken directly.
                        if (redir) begin
                            fetch_pc <= redir_tgt;
                        end else begin
                            if_pc       <= fetch_pc;
                            if_inst     <= NOP_INST;
                            if_ex_adef  <= 1'b1;
                            if_ready_go <= 1'b1;
                            state       <= S_HOLD;
                        end
                    end else if (inst_sram_addr_ok) begin
                        // The accepted request is on the old path if any redirect is known.
                        state       <= S_WAIT;
                        redir_valid <= 1'b0;
                        if (redir) begin
                            discard  <= 1'b1;
                            fetch_pc <= redir_tgt;
                        end else if (redir_valid) begin
                            discard  <= 1'b1;
                            fetch_pc <= redir_pc;
                        end
                    end else if (redir) begin
                        // Address must stay stable until accepted; remember the target.
                        redir_valid <= 1'b1;
                        redir_pc    <= redir_tgt;
                    end
                end
                S_WAIT: begin
                    if (inst_sram_data_ok) begin
                        if (redir || discard) begin
                            if (redir)
                                fetch_pc <= redir_tgt;
                            discard <= 1'b0;
                            state   <= S_REQ;
                        end else begin
                            if_inst     <= inst_sram_rdata;
                            if_pc       <= fetch_pc;
                            if_ex_adef  <= 1'b0;
                            if_ready_go <= 1'b1;
                            fetch_pc    <= fetch_pc + 32'd4;
                            state       <= S_HOLD;
                        end
                    end else if (redir) begin
                        discard  <= 1'b1;
                        fetch_pc <= redir_tgt;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Generates the fetch PC and drives the SRAM-like instruction port (req/addr_ok/data_ok).
- Buffers one fetched instruction and presents if_pc/if_inst/if_ready_go to ID.
- Handles redirects from branch (ID), exception and ertn (WB), including discarding an in-flight wrong-path response.

Parameters:
RESET_PC, 32'h1c000000, address of the first fetch after reset.
NOP_INST, 32'h02800000, instruction presented when the buffer is empty or an ADEF fault is flagged.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
id_allow_in  in  1  ID accepts if_pc/if_inst this cycle when if_ready_go=1
br_taken  in  1  ID-resolved taken branch; redirect request
br_target  in  32  branch target
wb_ex  in  1  exception flush from WB
ex_entry  in  32  exception entry PC
wb_is_ertn  in  1  ertn flush from WB
ertn_pc  in  32  return PC (ERA)
inst_sram_req  out  1  fetch request
inst_sram_addr  out  32  fetch address
inst_sram_addr_ok  in  1  address accepted
inst_sram_data_ok  in  1  read data valid
inst_sram_rdata  in  32  fetched instruction
if_ready_go  out  1  buffer holds a valid instruction for ID
if_pc  out  32  PC of the buffered instruction
if_inst  out  32  buffered instruction
if_ex_adef  out  1  buffered entry is an address-error fault (see Optional Feature)

Behaviour:
- Reset is synchronous, active-high, on clk.
- Reset values: state=IDLE, fetch_pc=RESET_PC, if_ready_go=0, if_pc=32'h1bfffffc, if_inst=NOP_INST, if_ex_adef=0, inst_sram_req=0, discard=0, redir_valid=0.
- At most one outstanding request; a data_ok in any state other than WAIT is a protocol error and is ignored.
- States:
  - IDLE: req=0. Next cycle goes to REQ. Reachable only from reset.
  - REQ: req=1, addr=fetch_pc. addr and req are held stable until addr_ok. On addr_ok go to WAIT.
  - WAIT: req=0. On data_ok:
    - If discard=1: drop rdata, clear discard, go to REQ.
    - Else: load if_inst=rdata, if_pc=fetch_pc, set if_ready_go=1, fetch_pc<=fetch_pc+4, go to HOLD.
  - HOLD: req=0, if_ready_go=1. On id_allow_in: clear if_ready_go and go to REQ, so the next fetch request is issued the cycle after consumption.
- Redirect priority when several occur in the same cycle: wb_ex (ex_entry) > wb_is_ertn (ertn_pc) > br_taken (br_target).
- Redirect handling by state:
  - IDLE/HOLD: fetch_pc<=target, if_ready_go<=0, if_inst<=NOP_INST, go to REQ. The redirect overrides a same-cycle consume.
  - REQ, no addr_ok: the address is not changed. Set redir_valid and redir_pc<=target. On addr_ok go to WAIT with discard=1 and fetch_pc<=redir_pc.
  - REQ with addr_ok in the same cycle: go to WAIT with discard=1 and fetch_pc<=target.
  - WAIT, no data_ok: discard<=1, fetch_pc<=target.
  - WAIT with data_ok in the same cycle: drop rdata, fetch_pc<=target, go to REQ.
- A later redirect overwrites an earlier pending one (redir_pc, fetch_pc); discard never counts above 1.
- PC arithmetic is modulo 2^32; 32'hfffffffc+4 wraps to 0.
- rst mid-operation returns every register to its reset value. The instruction SRAM is reset by the same rst, so no stale data_ok arrives.
- Minimum latency from redirect to if_ready_go, with addr_ok in the REQ cycle and data_ok one cycle later: 3 cycles.

Optional Feature:
- Macro: IF_ADEF_EN.
- Defined:
  - A REQ entry with fetch_pc[1:0]!=0 issues no request (req stays 0).
  - Next cycle the buffer loads if_pc=fetch_pc, if_inst=NOP_INST, if_ex_adef=1, if_ready_go=1, and the state goes to HOLD.
  - fetch_pc stops advancing until a redirect.
- Not defined: if_ex_adef is constant 0 and the misaligned address is issued unchanged.

Test Plan:
- Release rst; addr_ok immediate, data_ok 1 cycle later, id_allow_in=1 -> first req addr=0x1c000000; if_pc=0x1c000000 with rdata; next req addr=0x1c000004.
- Hold id_allow_in=0 for 5 cycles in HOLD -> if_pc/if_inst stable, req=0 throughout; on release, next req 1 cycle later.
- br_taken with br_target=0x1c000100 while in WAIT -> next data_ok rdata dropped (if_ready_go stays 0); next req addr=0x1c000100.
- addr_ok held 0 for 3 cycles, wb_ex with ex_entry=0x1c008000 in cycle 1 -> addr held at the old PC until addr_ok; that response dropped; next req addr=0x1c008000.
- wb_ex (0x1c008000), wb_is_ertn (0x1c000040) and br_taken (0x1c000100) in the same cycle in HOLD -> if_ready_go=0 next cycle; next req addr=0x1c008000.
- IF_ADEF_EN defined, br_target=0x1c000102 -> no req issued; if_ex_adef=1, if_pc=0x1c000102, if_inst=0x02800000, if_ready_go=1.
